axis_slave_rx: RTL
==================

# axis_slave_rx

Receive-side AXI4-Stream endpoint, the counterpart of `axis_master`: it accepts beats on an `S_AXIS` slave port, buffers them in a first-word-fall-through FIFO, and presents them to the data path on a simple valid/ready pop interface. It also reports per-packet beat counts, packet-completion pulses and a sticky partial-strobe error. It sits between the DMA stream and `data_path` so that ifmap/weight ingress is decoupled from MAC back-pressure.

## Interface
- `FIFO_DEPTH`, 4: number of buffered beats; a power of 2, at least 2.
- `C_S_AXIS_TDATA_WIDTH`, 32: stream data width; a multiple of 8.
- `S_AXIS_ACLK` in 1: the single clock; all logic is rising-edge.
- `S_AXIS_ARESETN` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous flush; drops FIFO contents and zeroes all counters and flags.
- `S_AXIS_TREADY` out 1: the block can accept a beat.
- `S_AXIS_TDATA` in `C_S_AXIS_TDATA_WIDTH`: stream data.
- `S_AXIS_TSTRB` in `C_S_AXIS_TDATA_WIDTH/8`: byte strobes; checked, not stored.
- `S_AXIS_TLAST` in 1: packet boundary.
- `S_AXIS_TVALID` in 1: upstream beat valid.
- `TDATA_out` out `C_S_AXIS_TDATA_WIDTH`: head-of-FIFO data.
- `TVALID_out` out 1: FIFO non-empty.
- `TLAST_out` out 1: TLAST of the head beat.
- `TREADY_in` in 1: consumer pops the head beat when asserted with `TVALID_out`.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: number of occupied entries.
- `beat_count` out 16: beats accepted so far in the current packet.
- `pkt_done` out 1: one-cycle pulse the cycle after a TLAST beat is accepted.
- `strb_err` out 1: sticky; set when an accepted beat has TSTRB not all-ones.

## Operation
- Push occurs when `S_AXIS_TVALID && S_AXIS_TREADY`. The entry stores {TLAST, TDATA}.
- Pop occurs when `TVALID_out && TREADY_in`. A pop on an empty FIFO is ignored.
- `S_AXIS_TREADY = rx_en && !full && !clear`, where `rx_en` is a register. It is 0 in reset and becomes 1 on the first clock edge after reset is released.
- `S_AXIS_TREADY` has no combinational dependence on `TREADY_in`.
  - When the FIFO is full, a simultaneous pop does not admit a push in the same cycle.
  - The freed slot becomes available on the next cycle.
- `TVALID_out = !empty`. `TDATA_out` and `TLAST_out` are read combinationally from the registered read pointer and memory.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits wide with a wrap bit.
  - full: the index bits are equal and the wrap bits differ.
  - empty: the pointers are equal.
  - Both pointers wrap naturally.
- `fifo_count` is incremented on push only, decremented on pop only, and unchanged on push and pop together.
- `beat_count` on a push:
  - TLAST=1: becomes 0.
  - otherwise: increments, saturating at 0xFFFF.
- `pkt_done` is registered and equals the previous cycle's push-with-TLAST.
- `strb_err` is set on a push whose TSTRB is not all-ones. It is cleared only by `clear` or reset.
- `clear` has priority over push and pop in the same cycle.
  - It zeroes both pointers, `fifo_count`, `beat_count`, `pkt_done` and `strb_err`.
  - `TREADY` is 0 during the clear cycle.
  - The beat offered in that cycle is not accepted; upstream holds it.
- Reset mid-packet is not special-cased: everything returns to reset values and the partial packet is lost.

## Timing
- Reset values:
  - `S_AXIS_TREADY` 0
  - `TVALID_out` 0
  - `TLAST_out` 0
  - `TDATA_out` 0 (memory entry 0 resets to 0)
  - `fifo_count` 0
  - `beat_count` 0
  - `pkt_done` 0
  - `strb_err` 0
- Latency: a beat pushed at edge N is visible on `TVALID_out`/`TDATA_out` after edge N (one cycle, no bypass).
- Throughput: one beat per cycle when pushing and popping continuously, for any `FIFO_DEPTH` ≥ 2.
- Upstream stall: TDATA, TLAST and TSTRB are sampled only on push cycles.

## Structure
- Shared package `axis_pkg`: the `clog2` helper and the `STRB_W = C_S_AXIS_TDATA_WIDTH/8` derivation. `axis_master` uses the same package.
- One sub-module, `axis_sync_fifo`, holds the memory, pointers, full/empty and count. It is parameterised on width and depth and has a `flush` input.
- Counters, strobe check and `rx_en` live in `axis_slave_rx` itself.

## Test plan
- Reset release, upstream presents 0xA5A5_0001..0004 with TLAST on the 4th beat and `TREADY_in`=1 → TREADY goes 1 one cycle after reset. Output shows the same four words one cycle later with TLAST on 0x...0004. `pkt_done` pulses once. `beat_count` ends at 0.
- `TREADY_in`=0, stream 5 beats with DEPTH=4 → 4 accepted. TREADY drops with `fifo_count`=4. Raising `TREADY_in` for one cycle pops 0x...0001 and TREADY returns on the following cycle; the 5th beat is accepted then.
- Continuous push and pop for 64 beats with incrementing data → no bubbles after the first. Output order matches input. Pointers wrap 16 times with no loss.
- Accepted beat with TSTRB=4'b0111 → `strb_err`=1 and it stays 1 across later full-strobe beats. `clear` → `strb_err`=0.
- `clear` asserted with 3 entries buffered, and TVALID high that cycle → next cycle `fifo_count`=0 and `TVALID_out`=0. The offered beat is not taken and is accepted on the next cycle.
- Assert `S_AXIS_ARESETN`=0 asynchronously mid-packet with `beat_count`=2 → all outputs return to reset values immediately without a clock edge.

Source files
------------

// File: rtl/axis_pkg.sv
// axis_pkg: helpers shared by the AXI4-Stream endpoints (axis_master,
// axis_slave_rx). Provides a constant-foldable clog2, the byte-strobe width
// derivation and the per-packet beat counter width.
package axis_pkg;

  localparam int BEAT_CNT_W = 16;
  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = '1;

  // Smallest r such that 2**r >= v (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Number of TSTRB bits for a given TDATA width (TDATA is a whole number of bytes).
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axis_slave_rx_if.sv
// axis_slave_rx_if: AXI4-Stream beat bundle (tvalid/tready/tdata/tstrb/tlast).
// Handshake: a beat transfers on a rising edge where tvalid && tready; once
// tvalid is raised the master holds tdata/tstrb/tlast stable until that edge,
// and tready may change freely while tvalid is low.
//   master modport: drives tvalid, tdata, tstrb, tlast; observes tready
//   slave  modport: drives tready; observes the beat signals
interface axis_slave_rx_if #(
  parameter int DATA_W = 32
);
  import axis_pkg::*;
  localparam int STRB_W = strb_w(DATA_W);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [STRB_W-1:0] tstrb;
  logic              tlast;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst_n   rising-edge clock, async active-low reset
//   flush        synchronous drop of all contents (wins over push/pop)
//   push, din    write din when push && !full
//   pop          discard head when pop && !empty
//   dout         head entry, read combinationally from the registered read pointer
//   full, empty  status from the wrap-bit pointers
//   count        occupied entries
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE = 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic do_push, do_pop;

  // Same slot index with opposite lap bits means the writer is one lap ahead.
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Memory is reset so the head output reads a defined zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (!flush && do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/axis_slave_rx.sv
// axis_slave_rx: AXI4-Stream receive endpoint. Buffers S_AXIS beats in a
// FWFT FIFO and offers them on a valid/ready pop port.
// Ports:
//   S_AXIS_ACLK, S_AXIS_ARESETN   clock, async active-low reset
//   clear                         synchronous flush of FIFO, counters and flags
//   S_AXIS_*                      AXI4-Stream slave port (TSTRB checked, not stored)
//   TDATA_out/TLAST_out/TVALID_out, TREADY_in   pop port (pop = TVALID_out && TREADY_in)
//   fifo_count                    occupied FIFO entries
//   beat_count                    beats accepted so far in the current packet
//   pkt_done                      one-cycle pulse after a TLAST beat is accepted
//   strb_err                      sticky: an accepted beat had a partial strobe
module axis_slave_rx
  import axis_pkg::*;
#(
  parameter int FIFO_DEPTH           = 4,
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                     S_AXIS_ACLK,
  input  logic                                     S_AXIS_ARESETN,
  input  logic                                     clear,
  output logic                                     S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_TDATA,
  input  logic [strb_w(C_S_AXIS_TDATA_WIDTH)-1:0]  S_AXIS_TSTRB,
  input  logic                                     S_AXIS_TLAST,
  input  logic                                     S_AXIS_TVALID,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]          TDATA_out,
  output logic                                     TVALID_out,
  output logic                                     TLAST_out,
  input  logic                                     TREADY_in,
  output logic [clog2(FIFO_DEPTH):0]               fifo_count,
  output logic [BEAT_CNT_W-1:0]                    beat_count,
  output logic                                     pkt_done,
  output logic                                     strb_err
);

  localparam int DW = C_S_AXIS_TDATA_WIDTH;

  logic                  rx_en_q, rx_en_d;
  logic [BEAT_CNT_W-1:0] beat_count_q, beat_count_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  strb_err_q, strb_err_d;

  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [DW:0]   fifo_dout;

  // TREADY depends only on registered state and clear, never on TREADY_in:
  // a slot freed by a pop on a full cycle is offered on the next cycle.
  assign S_AXIS_TREADY = rx_en_q && !fifo_full && !clear;
  assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pop           = TVALID_out && TREADY_in;

  assign TVALID_out = !fifo_empty;
  assign TDATA_out  = fifo_dout[DW-1:0];
  assign TLAST_out  = fifo_dout[DW];

  assign beat_count = beat_count_q;
  assign pkt_done   = pkt_done_q;
  assign strb_err   = strb_err_q;

  axis_sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (S_AXIS_ACLK),
    .rst_n (S_AXIS_ARESETN),
    .flush (clear),
    .push  (push),
    .din   ({S_AXIS_TLAST, S_AXIS_TDATA}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rx_en_d      = 1'b1;
    beat_count_d = beat_count_q;
    pkt_done_d   = 1'b0;
    strb_err_d   = strb_err_q;
    if (clear) begin
      beat_count_d = '0;
      strb_err_d   = 1'b0;
    end else if (push) begin
      pkt_done_d = S_AXIS_TLAST;
      if (S_AXIS_TLAST)
        beat_count_d = '0;
      else if (beat_count_q != BEAT_CNT_MAX)
        beat_count_d = beat_count_q + 16'd1;
      if (S_AXIS_TSTRB != '1) strb_err_d = 1'b1;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      rx_en_q      <= 1'b0;
      beat_count_q <= '0;
      pkt_done_q   <= 1'b0;
      strb_err_q   <= 1'b0;
    end else begin
      rx_en_q      <= rx_en_d;
      beat_count_q <= beat_count_d;
      pkt_done_q   <= pkt_done_d;
      strb_err_q   <= strb_err_d;
    end
  end

endmodule
